// File: rtl/g76_video_pkg.sv
// Shared video definitions: frame-buffer geometry, pixel/coordinate types and
// the rectangle-fill walker states.
package g76_video_pkg;

  localparam int SCREEN_WIDTH_C  = 320;
  localparam int SCREEN_HEIGHT_C = 240;

  typedef logic [8:0] x_coord_t;
  typedef logic [7:0] y_coord_t;
  typedef logic [7:0] pixel_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    ADVANCE,
    DONE
  } fill_state_t;

endpackage

// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: walks a rectangle row-major and writes one pixel per
// on-screen position through the memory manager's request/complete handshake.
// Optional checkerboard fill is enabled with RECT_FILL_PATTERN_EN.
module rect_fill_engine
  import g76_video_pkg::*;
#(
  parameter int SCREEN_WIDTH  = SCREEN_WIDTH_C,
  parameter int SCREEN_HEIGHT = SCREEN_HEIGHT_C
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     cmdValid,
  output logic     cmdReady,
  input  x_coord_t cmdX,
  input  y_coord_t cmdY,
  input  logic [8:0] cmdWidth,
  input  logic [7:0] cmdHeight,
  input  pixel_t   cmdColor,
`ifdef RECT_FILL_PATTERN_EN
  input  pixel_t   cmdColorAlt,
  input  logic     cmdPattern,
`endif
  output logic     busy,
  output logic     done,
  output x_coord_t memoryXCoord,
  output y_coord_t memoryYCoord,
  output logic     memoryWriteRequest,
  output pixel_t   memoryWriteData,
  input  logic     memoryWriteComplete
);

  fill_state_t r_state, w_state_next;
  x_coord_t    r_x, w_x_next;
  y_coord_t    r_y, w_y_next;
  logic [8:0]  r_w, w_w_next;
  logic [7:0]  r_h, w_h_next;
  pixel_t      r_color, w_color_next;
  logic [8:0]  r_col, w_col_next;
  logic [7:0]  r_row, w_row_next;
  logic        r_busy, w_busy_next;
  logic        r_done, w_done_next;
  logic        r_req, w_req_next;
  x_coord_t    r_mx, w_mx_next;
  y_coord_t    r_my, w_my_next;
  pixel_t      r_md, w_md_next;
  logic [9:0]  w_px;
  logic [8:0]  w_py;
  logic        w_on_screen;
  pixel_t      w_pixel;

  // Absolute pixel position is kept one bit wider so off-screen never wraps.
  assign w_px        = {1'b0, r_x} + {1'b0, r_col};
  assign w_py        = {1'b0, r_y} + {1'b0, r_row};
  assign w_on_screen = (w_px < 10'(SCREEN_WIDTH)) && (w_py < 9'(SCREEN_HEIGHT));

`ifdef RECT_FILL_PATTERN_EN
  pixel_t r_color_alt, w_color_alt_next;
  logic   r_pattern, w_pattern_next;

  // Checkerboard parity follows absolute screen coordinates, not the rectangle origin.
  assign w_pixel = (r_pattern && (w_px[0] ^ w_py[0])) ? r_color_alt : r_color;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_color_alt <= '0;
      r_pattern   <= 1'b0;
    end else begin
      r_color_alt <= w_color_alt_next;
      r_pattern   <= w_pattern_next;
    end
  end
`else
  assign w_pixel = r_color;
`endif

  assign cmdReady           = (r_state == IDLE) && !reset;
  assign busy               = r_busy;
  assign done               = r_done;
  assign memoryWriteRequest = r_req;
  assign memoryXCoord       = r_mx;
  assign memoryYCoord       = r_my;
  assign memoryWriteData    = r_md;

  always_comb begin
    // NOTE: every next-value gets a default before the case so no path infers a latch.
    w_state_next = r_state;
    w_x_next     = r_x;
    w_y_next     = r_y;
    w_w_next     = r_w;
    w_h_next     = r_h;
    w_color_next = r_color;
    w_col_next   = r_col;
    w_row_next   = r_row;
    w_busy_next  = r_busy;
    w_done_next  = 1'b0;
    w_req_next   = r_req;
    w_mx_next    = r_mx;
    w_my_next    = r_my;
    w_md_next    = r_md;
`ifdef RECT_FILL_PATTERN_EN
    w_color_alt_next = r_color_alt;
    w_pattern_next   = r_pattern;
`endif
    unique case (r_state)
      IDLE: begin
        w_busy_next = 1'b0;
        if (cmdValid) begin
          w_x_next     = cmdX;
          w_y_next     = cmdY;
          w_w_next     = cmdWidth;
          w_h_next     = cmdHeight;
          w_color_next = cmdColor;
`ifdef RECT_FILL_PATTERN_EN
          w_color_alt_next = cmdColorAlt;
          w_pattern_next   = cmdPattern;
`endif
          w_col_next   = '0;
          w_row_next   = '0;
          w_busy_next  = 1'b1;
          w_state_next = ((cmdWidth == '0) || (cmdHeight == '0)) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (w_on_screen) begin
          w_req_next   = 1'b1;
          w_mx_next    = w_px[8:0];
          w_my_next    = w_py[7:0];
          w_md_next    = w_pixel;
          w_state_next = WAIT;
        end else begin
          w_state_next = ADVANCE;
        end
      end
      WAIT: begin
        if (memoryWriteComplete) begin
          w_req_next   = 1'b0;
          w_state_next = ADVANCE;
        end
      end
      ADVANCE: begin
        if (r_col == r_w - 9'd1) begin
          w_col_next = '0;
          if (r_row == r_h - 8'd1) begin
            w_state_next = DONE;
          end else begin
            w_row_next   = r_row + 8'd1;
            w_state_next = ISSUE;
          end
        end else begin
          w_col_next   = r_col + 9'd1;
          w_state_next = ISSUE;
        end
      end
      DONE: begin
        w_done_next  = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_w     <= '0;
      r_h     <= '0;
      r_color <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_req   <= 1'b0;
      r_mx    <= '0;
      r_my    <= '0;
      r_md    <= '0;
    end else begin
      r_state <= w_state_next;
      r_x     <= w_x_next;
      r_y     <= w_y_next;
      r_w     <= w_w_next;
      r_h     <= w_h_next;
      r_color <= w_color_next;
      r_col   <= w_col_next;
      r_row   <= w_row_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
      r_req   <= w_req_next;
      r_mx    <= w_mx_next;
      r_my    <= w_my_next;
      r_md    <= w_md_next;
    end
  end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Directed bench for rect_fill_engine: a memory-manager model pops expected
// writes from a scoreboard queue and checks handshake stability.
module tb_rect_fill_engine;
  import g76_video_pkg::*;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [7:0] d;
  } wr_t;

  logic       clock;
  logic       reset;
  logic       cmdValid;
  logic       cmdReady;
  logic [8:0] cmdX;
  logic [7:0] cmdY;
  logic [8:0] cmdWidth;
  logic [7:0] cmdHeight;
  logic [7:0] cmdColor;
  logic [7:0] cmdColorAlt;
  logic       cmdPattern;
  logic       busy;
  logic       done;
  logic [8:0] memoryXCoord;
  logic [7:0] memoryYCoord;
  logic       memoryWriteRequest;
  logic [7:0] memoryWriteData;
  logic       memoryWriteComplete;

  wr_t exp_q[$];
  int  checks      = 0;
  int  errors      = 0;
  int  write_count = 0;
  int  done_count  = 0;
  int  cmpl_delay  = 3;
  bit  spurious    = 0;

  rect_fill_engine dut (
    .clock              (clock),
    .reset              (reset),
    .cmdValid           (cmdValid),
    .cmdReady           (cmdReady),
    .cmdX               (cmdX),
    .cmdY               (cmdY),
    .cmdWidth           (cmdWidth),
    .cmdHeight          (cmdHeight),
    .cmdColor           (cmdColor),
`ifdef RECT_FILL_PATTERN_EN
    .cmdColorAlt        (cmdColorAlt),
    .cmdPattern         (cmdPattern),
`endif
    .busy               (busy),
    .done               (done),
    .memoryXCoord       (memoryXCoord),
    .memoryYCoord       (memoryYCoord),
    .memoryWriteRequest (memoryWriteRequest),
    .memoryWriteData    (memoryWriteData),
    .memoryWriteComplete(memoryWriteComplete)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference walk: every on-screen pixel of the rectangle, row-major.
  task automatic push_rect(input int x, input int y, input int w, input int h,
                           input logic [7:0] c, input logic [7:0] alt, input bit pat);
    for (int r = 0; r < h; r++) begin
      for (int k = 0; k < w; k++) begin
        int px = x + k;
        int py = y + r;
        if (px < 320 && py < 240) begin
          wr_t e;
          e.x = 9'(px);
          e.y = 8'(py);
          e.d = (pat && (((px ^ py) & 1) == 1)) ? alt : c;
          exp_q.push_back(e);
        end
      end
    end
  endtask

  // Memory-manager model: completes each request cmpl_delay cycles after it appears.
  initial begin
    wr_t got;
    wr_t exp;
    bit  aborted;
    memoryWriteComplete = 1'b0;
    forever begin
      @(negedge clock);
      if (spurious) begin
        memoryWriteComplete = 1'b1;
        @(negedge clock);
        memoryWriteComplete = 1'b0;
        spurious = 0;
      end else if (!reset && memoryWriteRequest) begin
        got = '{memoryXCoord, memoryYCoord, memoryWriteData};
        write_count++;
        check("bus_x_on_screen", 32'(memoryXCoord < 9'd320), 32'd1);
        check("bus_y_on_screen", 32'(memoryYCoord < 8'd240), 32'd1);
        check("busy_during_write", 32'(busy), 32'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'(exp_q.size()), 32'd1);
        end else begin
          exp = exp_q.pop_front();
          check("write_x", 32'(got.x), 32'(exp.x));
          check("write_y", 32'(got.y), 32'(exp.y));
          check("write_data", 32'(got.d), 32'(exp.d));
        end
        aborted = 0;
        for (int i = 1; i < cmpl_delay && !aborted; i++) begin
          @(negedge clock);
          if (reset) aborted = 1;
          else begin
            check("hold_request", 32'(memoryWriteRequest), 32'd1);
            check("hold_payload", 32'({memoryXCoord, memoryYCoord, memoryWriteData}), 32'(got));
          end
        end
        if (!aborted) begin
          memoryWriteComplete = 1'b1;
          @(negedge clock);
          memoryWriteComplete = 1'b0;
          check("request_drops", 32'(memoryWriteRequest), 32'd0);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (done) begin
        done_count++;
        check("busy_with_done", 32'(busy), 32'd1);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_cmd(input logic [8:0] x, input logic [7:0] y, input logic [8:0] w,
                          input logic [7:0] h, input logic [7:0] c, input logic [7:0] alt,
                          input logic pat);
    check("cmd_ready_idle", 32'(cmdReady), 32'd1);
    cmdX        = x;
    cmdY        = y;
    cmdWidth    = w;
    cmdHeight   = h;
    cmdColor    = c;
    cmdColorAlt = alt;
    cmdPattern  = pat;
    cmdValid    = 1'b1;
    @(negedge clock);
    cmdValid = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
    check("cmd_ready_busy", 32'(cmdReady), 32'd0);
  endtask

  // Returns at the negedge where done is high; a timeout counts as a failure.
  task automatic wait_done(input string tag, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clock);
      if (done) seen = 1;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  task automatic finish_cmd(input string tag, input int budget, input int w0, input int nwr,
                            input int d0);
    wait_done(tag, budget);
    @(negedge clock);
    check("busy_low_after_done", 32'(busy), 32'd0);
    check("ready_after_done", 32'(cmdReady), 32'd1);
    repeat (3) @(negedge clock);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("write_count", 32'(write_count - w0), 32'(nwr));
    check("single_done", 32'(done_count - d0), 32'd1);
  endtask

  task automatic degenerate(input logic [8:0] w, input logic [7:0] h);
    int w0 = write_count;
    send_cmd(9'd40, 8'd40, w, h, 8'h11, 8'h00, 1'b0);
    check("degen_done_early", 32'(done), 32'd0);
    @(negedge clock);
    check("degen_done_pulse", 32'(done), 32'd1);
    check("degen_busy_pulse", 32'(busy), 32'd1);
    @(negedge clock);
    check("degen_done_clear", 32'(done), 32'd0);
    check("degen_busy_clear", 32'(busy), 32'd0);
    check("degen_ready", 32'(cmdReady), 32'd1);
    check("degen_no_writes", 32'(write_count - w0), 32'd0);
  endtask

  initial begin
    int w0;
    int d0;
    bit reached;
    reset       = 1'b1;
    cmdValid    = 1'b0;
    cmdX        = '0;
    cmdY        = '0;
    cmdWidth    = '0;
    cmdHeight   = '0;
    cmdColor    = '0;
    cmdColorAlt = '0;
    cmdPattern  = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_cmd_ready", 32'(cmdReady), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_request", 32'(memoryWriteRequest), 32'd0);
    check("rst_coords", 32'({memoryXCoord, memoryYCoord}), 32'd0);
    check("rst_data", 32'(memoryWriteData), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("idle_cmd_ready", 32'(cmdReady), 32'd1);

    // Basic 3x2 fill with first-request latency check.
    w0 = write_count; d0 = done_count;
    push_rect(10, 20, 3, 2, 8'hA5, 8'h00, 0);
    send_cmd(9'd10, 8'd20, 9'd3, 8'd2, 8'hA5, 8'h00, 1'b0);
    check("no_request_at_e0", 32'(memoryWriteRequest), 32'd0);
    @(negedge clock);
    check("first_request_e1", 32'(memoryWriteRequest), 32'd1);
    finish_cmd("basic_done_timeout", 300, w0, 6, d0);

    // Clipping at the bottom-right corner.
    w0 = write_count; d0 = done_count;
    push_rect(318, 239, 4, 3, 8'h3C, 8'h00, 0);
    send_cmd(9'd318, 8'd239, 9'd4, 8'd3, 8'h3C, 8'h00, 1'b0);
    finish_cmd("clip_done_timeout", 300, w0, 2, d0);

    // Start fully off-screen: every pixel clipped.
    w0 = write_count; d0 = done_count;
    send_cmd(9'd400, 8'd245, 9'd3, 8'd2, 8'hEE, 8'h00, 1'b0);
    finish_cmd("offscreen_done_timeout", 100, w0, 0, d0);

    degenerate(9'd0, 8'd5);
    degenerate(9'd5, 8'd0);

    // Stretched completion, then a stray complete pulse while idle.
    cmpl_delay = 10;
    w0 = write_count; d0 = done_count;
    push_rect(50, 60, 2, 1, 8'h5C, 8'h00, 0);
    send_cmd(9'd50, 8'd60, 9'd2, 8'd1, 8'h5C, 8'h00, 1'b0);
    finish_cmd("stretch_done_timeout", 300, w0, 2, d0);
    cmpl_delay = 3;
    w0 = write_count; d0 = done_count;
    spurious = 1;
    repeat (5) @(negedge clock);
    check("spurious_no_write", 32'(write_count - w0), 32'd0);
    check("spurious_no_done", 32'(done_count - d0), 32'd0);
    check("spurious_idle", 32'({busy, memoryWriteRequest, cmdReady}), 32'b001);

    // Reset while the third write of a 4x4 fill is outstanding.
    cmpl_delay = 20;
    w0 = write_count; d0 = done_count;
    push_rect(100, 50, 4, 4, 8'h77, 8'h00, 0);
    send_cmd(9'd100, 8'd50, 9'd4, 8'd4, 8'h77, 8'h00, 1'b0);
    reached = 0;
    for (int i = 0; i < 300 && !reached; i++) begin
      @(negedge clock);
      #1;
      if (write_count - w0 >= 3) reached = 1;
    end
    check("third_request_seen", 32'(reached), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check("reset_drops_request", 32'(memoryWriteRequest), 32'd0);
    check("reset_clears_busy", 32'(busy), 32'd0);
    check("reset_no_done", 32'(done), 32'd0);
    reset = 1'b0;
    exp_q.delete();
    cmpl_delay = 3;
    repeat (4) @(negedge clock);
    check("reset_no_done_pulse", 32'(done_count - d0), 32'd0);
    check("reset_writes", 32'(write_count - w0), 32'd3);
    w0 = write_count; d0 = done_count;
    push_rect(5, 5, 2, 2, 8'h5A, 8'h00, 0);
    send_cmd(9'd5, 8'd5, 9'd2, 8'd2, 8'h5A, 8'h00, 1'b0);
    finish_cmd("post_reset_done_timeout", 300, w0, 4, d0);

`ifdef RECT_FILL_PATTERN_EN
    w0 = write_count; d0 = done_count;
    push_rect(0, 0, 2, 2, 8'd11, 8'd22, 1);
    send_cmd(9'd0, 8'd0, 9'd2, 8'd2, 8'd11, 8'd22, 1'b1);
    finish_cmd("pattern_done_timeout", 300, w0, 4, d0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rect_fill_engine.md
Name: rect_fill_engine

Overview:
- Drawing engine upstream of the memory manager's write port: fills an axis-aligned rectangle of the 320x240, 8-bit-per-pixel frame buffer with one colour.
- Accepts one command through a valid/ready handshake.
- Walks the rectangle row-major and issues one write per on-screen pixel over the request/complete handshake (memoryXCoord/memoryYCoord/memoryWriteData/memoryWriteRequest -> memoryWriteComplete).
- Pixels outside the screen are clipped, not wrapped.

Parameters:
SCREEN_WIDTH, 320, visible columns; x >= SCREEN_WIDTH is clipped
SCREEN_HEIGHT, 240, visible rows; y >= SCREEN_HEIGHT is clipped

Ports:
clock  input  1  single system clock, all logic on posedge
reset  input  1  synchronous, active-high
cmdValid  input  1  command present
cmdReady  output  1  engine can accept command (high only in IDLE)
cmdX  input  9  left column
cmdY  input  8  top row
cmdWidth  input  9  columns, 0..511
cmdHeight  input  8  rows, 0..255
cmdColor  input  8  fill value
busy  output  1  high from acceptance until done pulse inclusive
done  output  1  one-cycle pulse when command retires
memoryXCoord  output  9  pixel column to memory manager
memoryYCoord  output  8  pixel row to memory manager
memoryWriteRequest  output  1  write request, level
memoryWriteData  output  8  pixel value
memoryWriteComplete  input  1  one-cycle pulse from memory manager

Behaviour:
- Reset values: cmdReady=0 during reset then 1 in IDLE; busy=0, done=0, memoryWriteRequest=0, memoryXCoord=0, memoryYCoord=0, memoryWriteData=0; state IDLE.
- All outputs registered except cmdReady (decoded from state).
- States: IDLE, ISSUE, WAIT, ADVANCE, DONE.
- IDLE:
  - On edge with cmdValid&&cmdReady, latch all cmd fields; col=0, row=0; busy<=1.
  - If cmdWidth==0 or cmdHeight==0 -> DONE with zero writes; else -> ISSUE.
- ISSUE:
  - px=cmdX+col (10-bit), py=cmdY+row (9-bit), no truncation.
  - If px<SCREEN_WIDTH and py<SCREEN_HEIGHT: memoryWriteRequest<=1, coords<=px/py truncated, data<=colour -> WAIT.
  - Otherwise -> ADVANCE with no request.
- WAIT:
  - Request, coords and data held stable.
  - On edge where memoryWriteComplete==1: memoryWriteRequest<=0 -> ADVANCE.
  - The request is therefore low before the memory manager's next arbitration slot, and no duplicate write occurs.
- ADVANCE:
  - If col==width-1: col<=0; then if row==height-1 -> DONE, else row<=row+1 -> ISSUE.
  - Else col<=col+1 -> ISSUE.
- DONE: done<=1 for one cycle, busy<=0 on the following edge, -> IDLE. cmdReady is 0 in DONE.
- Latency:
  - Acceptance edge E0; first request visible after E1.
  - Each written pixel costs ISSUE + WAIT (memory-manager-dependent, 6-7 cycles typical) + ADVANCE.
  - Each clipped pixel costs 2 cycles.
- memoryWriteComplete outside WAIT is ignored.
- cmdValid while busy is ignored (not queued).
- Reset mid-operation: request dropped on that edge, state IDLE, command discarded, no done pulse. The memory manager shares the same reset.
- Start coordinates fully off-screen: all pixels clipped, done still pulses, zero requests.

Optional Feature:
- Macro RECT_FILL_PATTERN_EN.
- Defined:
  - Extra input cmdColorAlt[7:0] and input cmdPattern (1 bit), both latched at acceptance.
  - When cmdPattern=1, pixel data = ((px^py)&1) ? cmdColorAlt : cmdColor, which gives a checkerboard anchored to absolute screen coordinates.
  - When cmdPattern=0, the block behaves exactly as without the macro.
- Undefined: ports absent; solid fill only.

Decomposition:
- Package g76_video_pkg holds:
  - SCREEN_WIDTH_C=320, SCREEN_HEIGHT_C=240.
  - Typedefs x_coord_t (logic[8:0]), y_coord_t (logic[7:0]), pixel_t (logic[7:0]).
  - Enum fill_state_t {IDLE, ISSUE, WAIT, ADVANCE, DONE}.
- No sub-module: the walker counters and FSM are small enough to stay in one module.

Test Plan:
- Reset then cmd (x=10,y=20,w=3,h=2,c=8'hA5), memory manager model completing 3 cycles after each request -> exactly 6 writes in order (10,20),(11,20),(12,20),(10,21),(11,21),(12,21), all data A5; one done pulse; busy high throughout.
- Clip: cmd (x=318,y=239,w=4,h=3) -> only (318,239),(319,239) written; done pulses; no x>=320 or y>=240 on the bus.
- Degenerate: w=0,h=5 and separately w=5,h=0 -> zero requests, done exactly 2 cycles after acceptance, cmdReady back high.
- Handshake stability: stretch complete to 10 cycles late -> request, coords and data constant until complete, request low the edge after; a spurious complete pulse in IDLE causes nothing.
- Reset mid-fill after the 2nd write of a 4x4 fill -> request low next cycle, no done, new command accepted afterwards and run correctly.
- RECT_FILL_PATTERN_EN: cmd (x=0,y=0,w=2,h=2,c=11,alt=22,pattern=1) -> data 11,22,22,11.
